// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/word/state types, S-box tables, round constants
// and the GF(2^8) helpers used by the iterative decryption core.
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;
    // Indexed [column][row]; element [0][0] is byte 0 in the MSBs.
    typedef logic [0:3][0:3][7:0] state_t;

    typedef enum logic [2:0] {
        IDLE,
        KEXP,
        INIT,
        ROUND,
        FINAL,
        DONE
    } dec_fsm_t;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    localparam byte_t RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t p  = 8'h00;
        byte_t x  = a;
        byte_t bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ x;
            x  = xtime(x);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Row r is rotated right by r columns.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t     o;
        logic [1:0] c;
        logic [1:0] r;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            c = 2'(i >> 2);
            r = 2'(i);
            o[c][r] = s[c - r][r];
        end
        return o;
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t     o;
        logic [1:0] c;
        logic [1:0] r;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            c = 2'(i >> 2);
            r = 2'(i);
            o[c][r] = INV_SBOX[s[c][r]];
        end
        return o;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t     o;
        logic [1:0] c;
        byte_t      a0, a1, a2, a3;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            c  = 2'(i);
            a0 = s[c][0];
            a1 = s[c][1];
            a2 = s[c][2];
            a3 = s[c][3];
            o[c][0] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[c][1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[c][2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[c][3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_dec_key_step.sv
// One AES-128 key-schedule step in either direction: forward produces rk[rnd]
// from rk[rnd-1], inverse produces rk[rnd-1] from rk[rnd].
module aes_dec_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_in,
    input  logic [3:0]   rnd,
    input  logic         inverse,
    output logic [127:0] rk_out
);

    word_t w0, w1, w2, w3;
    word_t f0, f1, f2, f3;
    word_t i0, i1, i2, i3;
    word_t rcon_word;

    assign {w0, w1, w2, w3} = rk_in;
    assign rcon_word = {RCON[rnd], 24'h000000};

    always_comb begin
        f0 = w0 ^ sub_word(rot_word(w3)) ^ rcon_word;
        f1 = w1 ^ f0;
        f2 = w2 ^ f1;
        f3 = w3 ^ f2;
    end

    // Undo the chained XORs first so the last word of rk[rnd-1] feeds SubWord.
    always_comb begin
        i3 = w3 ^ w2;
        i2 = w2 ^ w1;
        i1 = w1 ^ w0;
        i0 = w0 ^ sub_word(rot_word(i3)) ^ rcon_word;
    end

    assign rk_out = inverse ? {i0, i1, i2, i3} : {f0, f1, f2, f3};

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128 decryption core, one inverse round per clock.
// Optional rk10 cache enabled by defining AES_DEC_KEY_CACHE_EN.
module aes_decrypt
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key,
    input  logic         load,
    input  logic [127:0] ct,
    output logic [127:0] pt,
    output logic         valid,
    output logic         busy
);

    generate
        if (NK != 4) begin : g_nk_check
            $error("aes_decrypt supports only NK=4 (AES-128)");
        end
    endgenerate

    dec_fsm_t     fsm;
    logic [3:0]   round_cnt;
    logic [127:0] rk;
    logic [127:0] rk_next;
    state_t       st;
    state_t       sr_sb;
    state_t       round_out;
    logic [127:0] final_out;

    aes_dec_key_step u_key_step (
        .rk_in   (rk),
        .rnd     (round_cnt),
        .inverse (fsm != KEXP),
        .rk_out  (rk_next)
    );

    assign sr_sb     = inv_sub_bytes(inv_shift_rows(st));
    assign round_out = inv_mix_columns(state_t'(sr_sb ^ rk));
    assign final_out = sr_sb ^ rk;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] cache_key;
    logic [127:0] cache_rk10;
    logic [127:0] key_q;
    logic         cache_vld;
    logic         cache_hit;

    assign cache_hit = cache_vld && (key == cache_key);
`endif

    // round_cnt doubles as the key-step round index, so it is left at 10 on
    // the way into INIT and counts down through ROUND.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            round_cnt <= 4'd0;
            rk        <= '0;
            st        <= '0;
            pt        <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_key  <= '0;
            cache_rk10 <= '0;
            key_q      <= '0;
            cache_vld  <= 1'b0;
`endif
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    if (load) begin
                        st    <= ct;
                        valid <= 1'b0;
                        busy  <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
                        key_q <= key;
                        if (cache_hit) begin
                            rk        <= cache_rk10;
                            round_cnt <= 4'd10;
                            fsm       <= INIT;
                        end else begin
                            rk        <= key;
                            round_cnt <= 4'd1;
                            fsm       <= KEXP;
                        end
`else
                        rk        <= key;
                        round_cnt <= 4'd1;
                        fsm       <= KEXP;
`endif
                    end
                end
                KEXP: begin
                    rk <= rk_next;
                    if (round_cnt == 4'd10) begin
                        fsm <= INIT;
`ifdef AES_DEC_KEY_CACHE_EN
                        cache_key  <= key_q;
                        cache_rk10 <= rk_next;
                        cache_vld  <= 1'b1;
`endif
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                INIT: begin
                    st        <= st ^ rk;
                    rk        <= rk_next;
                    round_cnt <= 4'd9;
                    fsm       <= ROUND;
                end
                ROUND: begin
                    st <= round_out;
                    rk <= rk_next;
                    if (round_cnt == 4'd1) begin
                        fsm <= FINAL;
                    end else begin
                        round_cnt <= round_cnt - 4'd1;
                    end
                end
                FINAL: begin
                    pt        <= final_out;
                    valid     <= 1'b1;
                    busy      <= 1'b0;
                    round_cnt <= 4'd0;
                    fsm       <= DONE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt.sv
// Self-checking bench for aes_decrypt: known-answer and random vectors against
// an array-based InvCipher model, plus busy/reset/hold-load sequences.
module tb_aes_decrypt;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    logic         valid;
    logic         busy;

    always #5 clk = ~clk;

    aes_decrypt dut (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .load  (load),
        .ct    (ct),
        .pt    (pt),
        .valid (valid),
        .busy  (busy)
    );

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    int           vectorCount = 0;
    int           missCount   = 0;
    logic [7:0]   tbSbox    [256];
    logic [7:0]   tbInvSbox [256];
    vec_t         vecs [8];
    logic [127:0] lastPt;
    bit           cacheVld;
    logic [127:0] cacheKey;

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic buildSboxes();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gfMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            tbSbox[x]    = s;
            tbInvSbox[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] refDecrypt(input logic [127:0] k, input logic [127:0] c);
        logic [7:0]   w   [44][4];
        logic [7:0]   s   [4][4];
        logic [7:0]   tmp [4][4];
        logic [7:0]   t   [4];
        logic [7:0]   a   [4];
        logic [7:0]   t0;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = k[127 - 8 * (4 * i + j) -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i - 1][j];
            if (i % 4 == 0) begin
                t0   = t[0];
                t[0] = tbSbox[t[1]];
                t[1] = tbSbox[t[2]];
                t[2] = tbSbox[t[3]];
                t[3] = tbSbox[t0];
                rc   = 8'h01;
                for (int n = 1; n < i / 4; n++) rc = gfMul(rc, 8'h02);
                t[0] = t[0] ^ rc;
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i - 4][j] ^ t[j];
        end
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++) s[r][cc] = c[127 - 8 * (4 * cc + r) -: 8] ^ w[40 + cc][r];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int r = 0; r < 4; r++)
                for (int cc = 0; cc < 4; cc++) tmp[r][(cc + r) % 4] = s[r][cc];
            for (int r = 0; r < 4; r++)
                for (int cc = 0; cc < 4; cc++) s[r][cc] = tbInvSbox[tmp[r][cc]] ^ w[4 * rnd + cc][r];
            if (rnd > 0) begin
                for (int cc = 0; cc < 4; cc++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[r][cc];
                    s[0][cc] = gfMul(a[0], 8'h0e) ^ gfMul(a[1], 8'h0b) ^ gfMul(a[2], 8'h0d) ^ gfMul(a[3], 8'h09);
                    s[1][cc] = gfMul(a[0], 8'h09) ^ gfMul(a[1], 8'h0e) ^ gfMul(a[2], 8'h0b) ^ gfMul(a[3], 8'h0d);
                    s[2][cc] = gfMul(a[0], 8'h0d) ^ gfMul(a[1], 8'h09) ^ gfMul(a[2], 8'h0e) ^ gfMul(a[3], 8'h0b);
                    s[3][cc] = gfMul(a[0], 8'h0b) ^ gfMul(a[1], 8'h0d) ^ gfMul(a[2], 8'h09) ^ gfMul(a[3], 8'h0e);
                end
            end
        end
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++) res[127 - 8 * (4 * cc + r) -: 8] = s[r][cc];
        return res;
    endfunction

    // Expected latency of the next accepted block, tracking the optional key cache.
    task automatic expLatency(input logic [127:0] k, output int lat);
        lat = 21;
`ifdef AES_DEC_KEY_CACHE_EN
        if (cacheVld && k == cacheKey) lat = 11;
        cacheVld = 1'b1;
        cacheKey = k;
`endif
    endtask

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
        vectorCount++;
        if (got !== want) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [127:0] k, input logic [127:0] c);
        key  = k;
        ct   = c;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Counts edges until valid; key/ct are scrambled meanwhile to show they are not re-sampled.
    task automatic waitValid(output int lat, output bit busyOk);
        lat    = 0;
        busyOk = busy;
        for (int n = 1; n <= 60; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            if (valid) begin
                lat = n;
                if (busy) busyOk = 1'b0;
                break;
            end
            if (!busy) busyOk = 1'b0;
        end
    endtask

    task automatic runOne(input string name, input logic [127:0] k, input logic [127:0] c,
                          input logic [127:0] want);
        int lat;
        int expLat;
        bit busyOk;
        expLatency(k, expLat);
        applyStimulus(k, c);
        checkOutput({name, " valid cleared on accept"}, 128'(valid), 128'(0));
        checkOutput({name, " pt held after accept"}, pt, lastPt);
        waitValid(lat, busyOk);
        checkOutput({name, " latency"}, 128'(lat), 128'(expLat));
        checkOutput({name, " busy window"}, 128'(busyOk), 128'(1));
        checkOutput({name, " pt"}, pt, want);
        lastPt = want;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  lat;
        int  expLat;
        bit  busyOk;
        bit  stable;
        int  seen;
        bit  prevValid;
        int  texp [3];
        int  l1, l2, l3;

        rst  = 1'b1;
        load = 1'b0;
        key  = '0;
        ct   = '0;
        cacheVld = 1'b0;
        cacheKey = '0;
        lastPt   = '0;

        buildSboxes();
        vecs[0] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT};
        vecs[1] = '{key: B_KEY, ct: B_CT, pt: B_PT};
        for (int i = 2; i < 8; i++) begin
            vecs[i].key = {$urandom(), $urandom(), $urandom(), $urandom()};
            vecs[i].ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
            vecs[i].pt  = refDecrypt(vecs[i].key, vecs[i].ct);
        end

        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset pt", pt, 128'(0));
        checkOutput("reset valid", 128'(valid), 128'(0));
        checkOutput("reset busy", 128'(busy), 128'(0));

        for (int i = 0; i < 8; i++)
            runOne($sformatf("vec%0d", i), vecs[i].key, vecs[i].ct, vecs[i].pt);

        runOne("repeat C1 a", C1_KEY, C1_CT, C1_PT);
        runOne("repeat C1 b", C1_KEY, C1_CT, C1_PT);
        runOne("after repeat B", B_KEY, B_CT, B_PT);

        // A second load five cycles into a run must be ignored.
        expLatency(C1_KEY, expLat);
        applyStimulus(C1_KEY, C1_CT);
        repeat (4) tick();
        key  = B_KEY;
        ct   = B_CT;
        load = 1'b1;
        tick();
        load = 1'b0;
        waitValid(lat, busyOk);
        checkOutput("ignored load latency", 128'(lat + 5), 128'(expLat));
        checkOutput("ignored load busy", 128'(busyOk), 128'(1));
        checkOutput("ignored load pt", pt, C1_PT);
        stable = 1'b1;
        repeat (30) begin
            tick();
            if (!valid || pt !== C1_PT) stable = 1'b0;
        end
        checkOutput("ignored load no second op", 128'(stable), 128'(1));
        lastPt = C1_PT;

        // Reset in the middle of a run discards the partial result.
        expLatency(C1_KEY, expLat);
        applyStimulus(C1_KEY, C1_CT);
        repeat (11) tick();
        rst = 1'b1;
        tick();
        checkOutput("midrun reset valid", 128'(valid), 128'(0));
        checkOutput("midrun reset pt", pt, 128'(0));
        checkOutput("midrun reset busy", 128'(busy), 128'(0));
        rst = 1'b0;
        cacheVld = 1'b0;
        lastPt   = '0;
        runOne("post reset C1", C1_KEY, C1_CT, C1_PT);

        // load held high: back-to-back blocks, one valid cycle per block.
        expLatency(C1_KEY, l1);
        expLatency(C1_KEY, l2);
        expLatency(C1_KEY, l3);
        texp[0] = l1;
        texp[1] = texp[0] + 1 + l2;
        texp[2] = texp[1] + 1 + l3;
        key  = C1_KEY;
        ct   = C1_CT;
        load = 1'b1;
        tick();
        seen      = 0;
        prevValid = valid;
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (valid && !prevValid) begin
                checkOutput($sformatf("hold pulse%0d time", seen), 128'(t), 128'(texp[seen]));
                checkOutput($sformatf("hold pulse%0d pt", seen), pt, C1_PT);
                seen++;
                if (seen == 3) begin
                    load = 1'b0;
                    break;
                end
            end
            prevValid = valid;
        end
        load = 1'b0;
        checkOutput("hold pulse count", 128'(seen), 128'(3));
        lastPt = C1_PT;

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
